// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - instruction register plus registered RISC-V immediate extender
// Captures the instruction on ir_write, then builds the immediate from imm_src one cycle later.
module imm_extend_unit #(
    parameter logic [31:0] RESET_INSTR = 32'h00000013,
    parameter logic [31:0] ERR_FILL    = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ir_write,
    input  logic [31:0] i_instr_in,
    input  logic [2:0]  i_imm_src,
    output logic [31:0] o_instr_q,
    output logic [31:0] o_imm_ext,
    output logic        o_imm_valid,
    output logic        o_imm_err
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        DECODE = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_instr;
    logic [31:0] r_imm;
    logic        r_valid;
    logic        r_err;

    logic [31:0] w_instr_nxt;
    logic [31:0] w_imm_nxt;
    logic        w_valid_nxt;
    logic        w_err_nxt;
    logic [31:0] w_imm_fmt;
    logic        w_unsup;

    // Unlisted codes, and X/Z on imm_src, fall through to the default arm.
    always_comb begin
        w_imm_fmt = ERR_FILL;
        w_unsup   = 1'b1;
        case (i_imm_src)
            3'b000: begin
                w_imm_fmt = {{20{r_instr[31]}}, r_instr[31:20]};
                w_unsup   = 1'b0;
            end
            3'b001: begin
                w_imm_fmt = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
                w_unsup   = 1'b0;
            end
            3'b010: begin
                w_imm_fmt = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25],
                             r_instr[11:8], 1'b0};
                w_unsup   = 1'b0;
            end
            3'b011: begin
                w_imm_fmt = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20],
                             r_instr[30:21], 1'b0};
                w_unsup   = 1'b0;
            end
            3'b101: begin
                w_imm_fmt = {r_instr[31:12], 12'b0};
                w_unsup   = 1'b0;
            end
            default: begin
                w_imm_fmt = ERR_FILL;
                w_unsup   = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_instr_nxt = r_instr;
        w_imm_nxt   = r_imm;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        if (i_ir_write) begin
            // A new word always restarts decode; the previous immediate stays visible.
            w_instr_nxt = i_instr_in;
            w_valid_nxt = 1'b0;
            w_err_nxt   = 1'b0;
            w_state_nxt = DECODE;
        end else begin
            case (r_state)
                DECODE: begin
                    w_imm_nxt   = w_imm_fmt;
                    w_err_nxt   = w_unsup;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = READY;
                end
                READY:   w_state_nxt = READY;
                EMPTY:   w_state_nxt = EMPTY;
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= EMPTY;
            r_instr <= RESET_INSTR;
            r_imm   <= 32'h0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_imm   <= w_imm_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign o_instr_q   = r_instr;
    assign o_imm_ext   = r_imm;
    assign o_imm_valid = r_valid;
    assign o_imm_err   = r_err;

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - directed and randomized check of imm_extend_unit against a value-level model
module tb_imm_extend_unit;

    logic        clk;
    logic        reset;
    logic        ir_write;
    logic [31:0] instr_in;
    logic [2:0]  imm_src;
    logic [31:0] instr_q;
    logic [31:0] imm_ext;
    logic        imm_valid;
    logic        imm_err;

    int total;
    int bad;

    logic [31:0] m_instr;
    logic [31:0] m_imm;
    logic        m_valid;
    logic        m_err;
    bit          m_pending;

    imm_extend_unit dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_ir_write  (ir_write),
        .i_instr_in  (instr_in),
        .i_imm_src   (imm_src),
        .o_instr_q   (instr_q),
        .o_imm_ext   (imm_ext),
        .o_imm_valid (imm_valid),
        .o_imm_err   (imm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Immediate as a signed integer value, built from field weights rather than bit splicing.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] s,
                                            output logic err);
        int v;
        err = 1'b0;
        v   = 0;
        case (s)
            3'd0: begin
                v = int'((i >> 20) & 32'hFFF);
                if (i[31]) v -= 4096;
            end
            3'd1: begin
                v = int'(((i >> 25) & 32'h7F) * 32 + ((i >> 7) & 32'h1F));
                if (i[31]) v -= 4096;
            end
            3'd2: begin
                v = int'(((i >> 8) & 32'hF) * 2 + ((i >> 25) & 32'h3F) * 32
                         + ((i >> 7) & 32'h1) * 2048);
                if (i[31]) v -= 4096;
            end
            3'd3: begin
                v = int'(((i >> 21) & 32'h3FF) * 2 + ((i >> 20) & 32'h1) * 2048
                         + ((i >> 12) & 32'hFF) * 4096);
                if (i[31]) v -= (1 << 20);
            end
            3'd5: return i - (i % 4096);
            default: begin
                err = 1'b1;
                return 32'h0;
            end
        endcase
        return 32'(v);
    endfunction

    task automatic cyc(input logic rst, input logic wr, input logic [31:0] ins,
                       input logic [2:0] src);
        logic e;
        logic [31:0] x;
        @(negedge clk);
        reset    = rst;
        ir_write = wr;
        instr_in = ins;
        imm_src  = src;
        @(posedge clk);
        if (rst) begin
            m_instr = 32'h00000013; m_imm = 32'h0; m_valid = 1'b0; m_err = 1'b0;
            m_pending = 1'b0;
        end else if (wr) begin
            m_instr = ins; m_valid = 1'b0; m_err = 1'b0; m_pending = 1'b1;
        end else if (m_pending) begin
            x = ref_imm(m_instr, src, e);
            m_imm = x; m_err = e; m_valid = 1'b1; m_pending = 1'b0;
        end
        #1;
        check("instr_q", instr_q, m_instr);
        check("imm_ext", imm_ext, m_imm);
        check("imm_valid", 32'(imm_valid), 32'(m_valid));
        check("imm_err", 32'(imm_err), 32'(m_err));
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; ir_write = 1'b0; instr_in = 32'h0; imm_src = 3'd0;
        m_instr = 32'h00000013; m_imm = 32'h0; m_valid = 1'b0; m_err = 1'b0;
        m_pending = 1'b0;

        cyc(1, 0, 32'h0, 3'd0);
        cyc(1, 1, 32'hDEADBEEF, 3'd0);
        check("rst_instr", instr_q, 32'h00000013);
        check("rst_imm", imm_ext, 32'h0);
        check("rst_valid", 32'(imm_valid), 32'h0);

        // lw: write, then decode with I format
        cyc(0, 1, 32'hFFC12283, 3'd0);
        check("t1_instr", instr_q, 32'hFFC12283);
        check("t1_valid_w", 32'(imm_valid), 32'h0);
        cyc(0, 0, 32'h0, 3'd0);
        check("t1_imm", imm_ext, 32'hFFFFFFFC);
        check("t1_valid", 32'(imm_valid), 32'h1);
        check("t1_err", 32'(imm_err), 32'h0);

        // READY ignores imm_src changes
        for (int k = 0; k < 3; k++) cyc(0, 0, 32'h0, 3'd1);
        for (int k = 0; k < 3; k++) cyc(0, 0, 32'h0, 3'd7);
        check("t4_hold_imm", imm_ext, 32'hFFFFFFFC);
        check("t4_hold_valid", 32'(imm_valid), 32'h1);

        cyc(0, 1, 32'h00612423, 3'd0);
        cyc(0, 0, 32'h0, 3'd1);
        check("t2_sw", imm_ext, 32'h00000008);
        cyc(0, 1, 32'h123452B7, 3'd0);
        cyc(0, 0, 32'h0, 3'd5);
        check("t2_lui", imm_ext, 32'h12345000);
        cyc(0, 1, 32'hFE000CE3, 3'd0);
        cyc(0, 0, 32'h0, 3'd2);
        check("t3_beq", imm_ext, 32'hFFFFFFF8);
        cyc(0, 1, 32'h001000EF, 3'd0);
        cyc(0, 0, 32'h0, 3'd3);
        check("t3_jal", imm_ext, 32'h00000800);

        // unsupported code in decode
        cyc(0, 1, 32'hFFC12283, 3'd0);
        cyc(0, 0, 32'h0, 3'd7);
        check("t4_err_imm", imm_ext, 32'h0);
        check("t4_err", 32'(imm_err), 32'h1);
        check("t4_err_valid", 32'(imm_valid), 32'h1);

        // back-to-back writes: only the second word decodes
        cyc(0, 1, 32'hFFC12283, 3'd0);
        check("t5_valid_w1", 32'(imm_valid), 32'h0);
        cyc(0, 1, 32'h00612423, 3'd0);
        check("t5_valid_w2", 32'(imm_valid), 32'h0);
        check("t5_imm_held", imm_ext, 32'h0);
        cyc(0, 0, 32'h0, 3'd1);
        check("t5_imm", imm_ext, 32'h00000008);
        check("t5_valid", 32'(imm_valid), 32'h1);

        // reset in DECODE aborts the instruction
        cyc(0, 1, 32'h123452B7, 3'd5);
        cyc(1, 0, 32'h0, 3'd5);
        check("t6_instr", instr_q, 32'h00000013);
        check("t6_imm", imm_ext, 32'h0);
        check("t6_valid", 32'(imm_valid), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 32'h0, 3'($urandom_range(0, 7)));
            check("t6_idle_valid", 32'(imm_valid), 32'h0);
        end

        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                $urandom, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
